// File: rtl/fpdlink_tx_encoder_pkg.sv
// FPD-Link transmit encoder shared definitions: half-word bit positions, widths, FSM encoding.
// Latency: n/a (constants and a pure packing function).
// Backpressure: n/a.
package fpdlink_tx_encoder_pkg;

    localparam int PIX_W  = 18;   // {r[5:0], g[5:0], b[5:0]}
    localparam int HALF_W = 21;   // one pixel plus DE/VS/HS, 3 lanes x 7 bits
    localparam int WORD_W = 2 * HALF_W;
    localparam int CNT_W  = 12;

    // Bit positions inside one 21-bit half (odd half sits 21 above these)
    localparam int POS_G0      = 20;
    localparam int POS_R_LSB   = 14;  // r[5:0] at 19:14
    localparam int POS_B10_LSB = 12;  // b[1:0] at 13:12
    localparam int POS_G51_LSB = 7;   // g[5:1] at 11:7
    localparam int POS_DE      = 6;
    localparam int POS_VS      = 5;
    localparam int POS_HS      = 4;
    localparam int POS_B52_LSB = 0;   // b[5:2] at 3:0

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [HALF_W-1:0] half_t;

    // Scatter one RGB666 pixel and the timing flags into the lane bit order
    function automatic half_t pack_half(input logic [PIX_W-1:0] pix,
                                        input logic de, input logic vs, input logic hs);
        half_t      w;
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        r = pix[17:12];
        g = pix[11:6];
        b = pix[5:0];
        w = '0;
        w[POS_G0]              = g[0];
        w[POS_R_LSB   +: 6]    = r;
        w[POS_B10_LSB +: 2]    = b[1:0];
        w[POS_G51_LSB +: 5]    = g[5:1];
        w[POS_DE]              = de;
        w[POS_VS]              = vs;
        w[POS_HS]              = hs;
        w[POS_B52_LSB +: 4]    = b[5:2];
        return w;
    endfunction

endpackage

// File: rtl/fpdlink_tx_encoder_video_timing_gen.sv
// Video timing generator: h/v counters with active/sync window decode and frame-origin flag.
// Latency: decodes are combinational from the current counter values; counters step on advance_i.
// Backpressure: none; counters hold at their value whenever advance_i is low.
module video_timing_gen
    import fpdlink_tx_encoder_pkg::*;
#(
    parameter int H_ACTIVE = 400,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 10,
    parameter int H_BP     = 20,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic advance_i,
    output logic de_o,
    output logic hs_o,
    output logic vs_o,
    output logic origin_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYN_S  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYN_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN_S  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYN_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Raster advance: h wraps at end of line and bumps v, v wraps at end of frame
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (advance_i) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
            end
        end
    end

    // Region decode; hs runs on every line including vertical blanking
    always_comb begin
        de_o     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_o     = (h_cnt_q >= H_SYN_S) && (h_cnt_q < H_SYN_E);
        vs_o     = (v_cnt_q >= V_SYN_S) && (v_cnt_q < V_SYN_E);
        origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

endmodule

// File: rtl/fpdlink_tx_encoder.sv
// Dual-pixel FPD-Link TX encoder: timing + RGB666 pair packing into the 42-bit serializer word.
// Latency: dout/frame_start one cycle after the counter position and pixel pair; pix_ready same cycle.
// Backpressure: none upstream-wards; a missing pair is replaced by black and flagged as sticky underflow.
module fpdlink_tx_encoder
    import fpdlink_tx_encoder_pkg::*;
#(
    parameter int H_ACTIVE = 400,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 10,
    parameter int H_BP     = 20,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix_odd,
    input  logic [PIX_W-1:0]  pix_even,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr,
    output logic [WORD_W-1:0] dout
);

    state_e state_q, state_d;
    logic   run_now;

    logic tg_de, tg_hs, tg_vs, tg_origin;

    logic [PIX_W-1:0]  slot_odd, slot_even;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              frame_start_q, frame_start_d;
    logic              underflow_q, underflow_d;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .advance_i (run_now),
        .de_o      (tg_de),
        .hs_o      (tg_hs),
        .vs_o      (tg_vs),
        .origin_o  (tg_origin)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: en is only looked at while the raster sits at the frame origin
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en)               state_d = ST_RUN;
            ST_RUN:  if (tg_origin && !en) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the cycle that leaves IDLE is already frame cycle (0,0)
    always_comb begin
        run_now = 1'b0;
        case (state_q)
            ST_IDLE: run_now = en;
            ST_RUN:  run_now = !(tg_origin && !en);
            default: run_now = 1'b0;
        endcase
    end

    // Handshake: ready is held low through reset so it drops asynchronously with the outputs
    assign pix_ready = run_now && tg_de && !rst;

    // Pair selection and next output word; blanking and idle words carry no colour
    always_comb begin
        slot_odd      = (pix_ready && pix_valid) ? pix_odd  : '0;
        slot_even     = (pix_ready && pix_valid) ? pix_even : '0;
        dout_d        = '0;
        if (run_now) begin
            dout_d = {pack_half(slot_odd,  tg_de, tg_vs, tg_hs),
                      pack_half(slot_even, tg_de, tg_vs, tg_hs)};
        end
        frame_start_d = run_now && tg_origin;
        underflow_d   = underflow_q;
        if (pix_ready && !pix_valid) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    // Output register toward the serializer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q        <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign dout        = dout_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fpdlink_tx_encoder.sv
// Bench for fpdlink_tx_encoder: random pixel stream against a raster-position reference model.
// Latency: model expects dout/frame_start/underflow one clock after the cycle they describe.
// Backpressure: model replaces unaccepted active pairs by black and tracks the sticky underflow.
module tb_fpdlink_tx_encoder;

    localparam int H_ACT  = 4;
    localparam int H_FP   = 1;
    localparam int H_SYN  = 2;
    localparam int H_BP   = 1;
    localparam int V_ACT  = 3;
    localparam int V_FP   = 1;
    localparam int V_SYN  = 1;
    localparam int V_BP   = 1;
    localparam int H_TOT  = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT  = V_ACT + V_FP + V_SYN + V_BP;
    localparam int F_TOT  = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [17:0] pix_odd;
    logic [17:0] pix_even;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;
    logic [41:0] dout;

    fpdlink_tx_encoder #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYN), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYN), .V_BP (V_BP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pix_odd       (pix_odd),
        .pix_even      (pix_even),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .dout          (dout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: position inside the frame (0..F_TOT-1) and whether a frame is in flight
    int          pos     = 0;
    bit          running = 1'b0;
    bit          e_fs, e_uf, e_de;
    logic [2:0]  e_ctl;
    logic [17:0] e_odd, e_even;
    int          fs_seen = 0;
    bit          color_probe = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Receiver-side view of one 21-bit half: back to {r,g,b} and {de,vs,hs}
    function automatic logic [17:0] dec_pix(input logic [20:0] h);
        logic [5:0] r, g, b;
        r = h[19:14];
        g = {h[11:7], h[20]};
        b = {h[3:0], h[13:12]};
        return {r, g, b};
    endfunction

    function automatic logic [2:0] dec_ctl(input logic [20:0] h);
        return {h[6], h[5], h[4]};
    endfunction

    function automatic bit in_de(input int p);
        return ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
    endfunction

    // One clock: inputs are already driven just after a falling edge
    task automatic cycle();
        bit fc, de, hs, vs;
        int h, v;
        #1;
        h  = pos % H_TOT;
        v  = pos / H_TOT;
        fc = !rst && ((pos == 0) ? en : running);
        de = fc && (h < H_ACT) && (v < V_ACT);
        hs = fc && (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYN);
        vs = fc && (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYN);
        chk("pix_ready", pix_ready, de);
        e_fs   = fc && (pos == 0);
        e_de   = de;
        e_ctl  = {de, vs, hs};
        e_odd  = (de && pix_valid) ? pix_odd  : 18'd0;
        e_even = (de && pix_valid) ? pix_even : 18'd0;
        if (rst)                   e_uf = 1'b0;
        else if (de && !pix_valid) e_uf = 1'b1;
        else if (underflow_clr)    e_uf = 1'b0;
        if (rst) begin
            pos = 0; running = 1'b0;
        end else if (fc) begin
            pos = (pos + 1) % F_TOT; running = 1'b1;
        end else begin
            running = 1'b0;
        end
        @(negedge clk);
        chk("odd_pix",     dec_pix(dout[41:21]), e_odd);
        chk("even_pix",    dec_pix(dout[20:0]),  e_even);
        chk("odd_ctl",     dec_ctl(dout[41:21]), e_ctl);
        chk("even_ctl",    dec_ctl(dout[20:0]),  e_ctl);
        chk("frame_start", frame_start, e_fs);
        chk("underflow",   underflow,   e_uf);
        if (frame_start) fs_seen++;
        if (color_probe && e_de) begin
            chk("red_bits",   dout[40:35], 6'h3F);
            chk("green_bits", dout[11:7],  5'h1F);
            chk("green_lsb",  dout[20],    1'b1);
            chk("other_rgb",  {dout[41], dout[34:28], dout[24:21], dout[19:12], dout[3:0]}, 24'd0);
        end
    endtask

    task automatic drive_rand(input int valid_pct, input int clr_pct);
        pix_odd       = 18'($urandom);
        pix_even      = 18'($urandom);
        pix_valid     = ($urandom_range(99) < valid_pct);
        underflow_clr = ($urandom_range(99) < clr_pct);
    endtask

    // Run until the model reaches a given frame position, bounded
    task automatic run_to(input int target, input string tag);
        for (int i = 0; i < 4 * F_TOT && pos != target; i++) begin
            drive_rand(100, 0);
            cycle();
        end
        chk(tag, pos, target);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pix_valid = 1'b0; underflow_clr = 1'b0;
        pix_odd = '0; pix_even = '0;
        e_fs = 0; e_uf = 0; e_de = 0; e_ctl = '0; e_odd = '0; e_even = '0;
        @(negedge clk);
        chk("rst_dout", dout, 42'd0);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_uf", underflow, 1'b0);
        cycle();
        rst = 1'b0;

        // Idle with en low: nothing moves
        for (int i = 0; i < 5; i++) begin drive_rand(100, 0); cycle(); end

        // Two frames of random pixels, always valid
        en = 1'b1;
        for (int i = 0; i < 2 * F_TOT; i++) begin drive_rand(100, 0); cycle(); end

        // Fixed red/green pattern and explicit bit positions
        color_probe = 1'b1;
        for (int i = 0; i < F_TOT; i++) begin
            pix_odd = 18'h3F000; pix_even = 18'h00FC0; pix_valid = 1'b1; underflow_clr = 1'b0;
            cycle();
        end
        color_probe = 1'b0;

        // Directed underflow: single missing pair, stickiness, clear, clear colliding with event
        for (int i = 0; i < F_TOT && !in_de(pos); i++) begin drive_rand(100, 0); cycle(); end
        drive_rand(100, 0); pix_valid = 1'b0; cycle();
        for (int i = 0; i < 10; i++) begin drive_rand(100, 0); cycle(); end
        chk("uf_sticky", underflow, 1'b1);
        drive_rand(100, 0); underflow_clr = 1'b1; cycle();
        chk("uf_cleared", underflow, 1'b0);
        for (int i = 0; i < F_TOT && !in_de(pos); i++) begin drive_rand(100, 0); cycle(); end
        drive_rand(100, 0); pix_valid = 1'b0; underflow_clr = 1'b1; cycle();
        chk("uf_set_wins", underflow, 1'b1);
        drive_rand(100, 0); underflow_clr = 1'b1; cycle();

        // Loopback: three frames of random valid/clear traffic
        for (int i = 0; i < 3 * F_TOT; i++) begin drive_rand(85, 10); cycle(); end

        // en dropped mid-frame: frame completes, then no restart
        run_to(10, "align_en_drop");
        en = 1'b0;
        fs_seen = 0;
        for (int i = 0; i < 2 * F_TOT; i++) begin drive_rand(100, 0); cycle(); end
        chk("no_restart", fs_seen, 0);
        chk("idle_dout", dout, 42'd0);

        // Reset mid-frame: outputs drop without a clock edge, fresh frame afterwards
        en = 1'b1;
        run_to(20, "align_rst");
        rst = 1'b1;
        #1;
        chk("async_dout", dout, 42'd0);
        chk("async_ready", pix_ready, 1'b0);
        chk("async_fs", frame_start, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        fs_seen = 0;
        for (int i = 0; i < F_TOT + 4; i++) begin drive_rand(90, 5); cycle(); end
        chk("restart_fs", fs_seen, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
